mul_fx_pipe: RTL

//  Pipelined fixed-point multiplier, U/S(W-F,F) x U/S(W-F,F) -> U/S(W-F,F).

---
 rtl/mul_fx_pipe.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mul_fx_pipe.sv
// Pipelined fixed-point multiplier, U/S(W-F,F) x U/S(W-F,F) -> U/S(W-F,F),
// with a valid/ready handshake, optional round-half-up and saturation.
module mul_fx_pipe #(
  parameter int TOTAL_BITS      = 16,
  parameter int FRACTIONAL_BITS = 8,
  parameter int SIGNED          = 1,
  parameter int STAGES          = 2,
  parameter int ROUND           = 1,
  parameter int SATURATE        = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TOTAL_BITS-1:0] in1,
  input  logic [TOTAL_BITS-1:0] in2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TOTAL_BITS-1:0] out,
  output logic                  overflow
);

  localparam int W  = TOTAL_BITS;
  localparam int F  = FRACTIONAL_BITS;
  localparam int NP = (STAGES > 2) ? STAGES - 2 : 1;
  localparam logic [2*W:0] RND = (ROUND != 0) ? ((2*W+1)'(1) << (F - 1)) : '0;

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
  // The whole pipe moves as one (adv); a stalled output freezes every stage,
  // bubbles included, and in_ready never depends on in_valid.
  logic              adv;
  logic [STAGES-1:0] vld;
  logic [STAGES:0]   chain;

  assign chain     = {vld, in_valid};
  assign out_valid = chain[STAGES];
  assign adv       = !chain[STAGES] || out_ready;
  assign in_ready  = adv;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
    end else if (adv) begin
      vld <= chain[STAGES-1:0];
    end
  end

  logic [W-1:0] op1, op2;

  generate
    if (STAGES >= 2) begin : g_opreg
      logic [W-1:0] a_q, b_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= in1;
          b_q <= in2;
        end
      end
      assign op1 = a_q;
      assign op2 = b_q;
    end else begin : g_opdir
      assign op1 = in1;
      assign op2 = in2;
    end
  endgenerate

  // Operands widened to 2W first, so the modulo-2^2W product is exact for both signednesses.
  logic [2*W-1:0] x1, x2, prod_comb, prod_src;

  always_comb begin
    x1 = {{W{(SIGNED != 0) ? op1[W-1] : 1'b0}}, op1};
    x2 = {{W{(SIGNED != 0) ? op2[W-1] : 1'b0}}, op2};
    prod_comb = x1 * x2;
  end

  generate
    if (STAGES > 2) begin : g_pslice
      logic [2*W-1:0] p_q [NP];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < NP; i++) p_q[i] <= '0;
        end else if (adv) begin
          p_q[0] <= prod_comb;
          for (int i = 1; i < NP; i++) p_q[i] <= p_q[i-1];
        end
      end
      assign prod_src = p_q[NP-1];
    end else begin : g_pdir
      assign prod_src = prod_comb;
    end
  endgenerate

  logic [2*W:0] r, q;
  logic [W-1:0] bound, res_c;
  logic         ovf_c;

  always_comb begin
    r     = {(SIGNED != 0) ? prod_src[2*W-1] : 1'b0, prod_src} + RND;
    q     = '0;
    bound = '1;
    ovf_c = 1'b0;
    if (SIGNED != 0) begin
      q     = $signed(r) >>> F;
      ovf_c = !((&q[2*W:W-1]) || (~|q[2*W:W-1]));
      bound = q[2*W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      q     = r >> F;
      ovf_c = |q[2*W:W];
    end
    res_c = (ovf_c && (SATURATE != 0)) ? bound : q[W-1:0];
  end

  // Output register only loads real results, so out/overflow hold across bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out      <= '0;
      overflow <= 1'b0;
    end else if (adv && chain[STAGES-1]) begin
      out      <= res_c;
      overflow <= ovf_c;
    end
  end

endmodule
